// File: rtl/outport_uart_tx_if.sv
// Write bus from the CPU output port into the UART transmitter.
interface outport_uart_tx_if;
    logic        OutPortin;
    logic [31:0] OutPortData;

    modport master (output OutPortin, output OutPortData);
    modport slave  (input  OutPortin, input  OutPortData);
endinterface

// File: rtl/outport_uart_tx.sv
// Queues CPU output-port words and streams each as four LSB-first UART bytes.
// Define OUTPORT_UART_PARITY_EN to add an even-parity bit to every frame.
module outport_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_W        = 4
) (
    input  logic             clock,
    input  logic             clear,
    outport_uart_tx_if.slave i_port,
    output logic             tx,
    output logic             busy,
    output logic             fifo_full,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

`ifdef OUTPORT_UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_byte;
    logic [2:0]      r_bit;
    logic [BW-1:0]   r_baud;
    logic [31:0]     r_shift;
    logic [31:0]     r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CNT_W-1:0] r_count;
    logic            r_overflow;

    logic            w_tick;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic [7:0]      w_cur;

    assign w_tick  = (r_baud == BAUD_MAX);
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_cur   = r_shift[{r_byte, 3'b000} +: 8];

    // A new word is loaded from IDLE, or at the end of the last stop bit
    // so consecutive words run without an idle gap.
    assign w_pop  = !w_empty &&
                    ((r_state == IDLE) ||
                     (r_state == STOP && w_tick && r_byte == 2'd3));
    assign w_push = i_port.OutPortin && (!w_full || w_pop);

    always_ff @(posedge clock) begin
        if (clear) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:   if (w_pop) w_state_nxt = START;
            START:  if (w_tick) w_state_nxt = DATA;
`ifdef OUTPORT_UART_PARITY_EN
            DATA:   if (w_tick && r_bit == 3'd7) w_state_nxt = PARITY;
            PARITY: if (w_tick) w_state_nxt = STOP;
`else
            DATA:   if (w_tick && r_bit == 3'd7) w_state_nxt = STOP;
`endif
            STOP:   if (w_tick)
                        w_state_nxt = (r_byte != 2'd3 || w_pop) ? START : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        unique case (r_state)
            START:  tx = 1'b0;
            DATA:   tx = w_cur[r_bit];
`ifdef OUTPORT_UART_PARITY_EN
            PARITY: tx = ^w_cur;
`endif
            default: tx = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_byte  <= '0;
            r_bit   <= '0;
            r_baud  <= '0;
            r_shift <= '0;
        end else begin
            if (r_state == IDLE || w_tick) r_baud <= '0;
            else                           r_baud <= r_baud + 1'b1;
            if (w_pop) begin
                r_shift <= r_mem[r_rptr];
                r_byte  <= '0;
            end else if (r_state == STOP && w_tick) begin
                r_byte <= r_byte + 1'b1;
            end
            if (r_state == START)              r_bit <= '0;
            else if (r_state == DATA && w_tick) r_bit <= r_bit + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr] <= i_port.OutPortData;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
            if (i_port.OutPortin && !w_push) r_overflow <= 1'b1;
        end
    end

    assign busy       = (r_state != IDLE) || !w_empty;
    assign fifo_full  = w_full;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
endmodule

// File: tb/tb_outport_uart_tx.sv
// Bench for outport_uart_tx: table vectors, corner sequences and random
// traffic checked against a timing-level reference model and a UART decoder.
module tb_outport_uart_tx;
    localparam int CPB = 4;
    localparam int D   = 8;
    localparam int CW  = 4;
`ifdef OUTPORT_UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int WCYC = 4 * FB * CPB;

    logic          clk   = 1'b0;
    logic          clear = 1'b1;
    logic          tx;
    logic          busy;
    logic          full;
    logic          ovf;
    logic [CW-1:0] cnt;

    outport_uart_tx_if bus ();

    outport_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (D),
        .CNT_W       (CW)
    ) dut (
        .clock     (clk),
        .clear     (clear),
        .i_port    (bus.slave),
        .tx        (tx),
        .busy      (busy),
        .fifo_full (full),
        .fifo_count(cnt),
        .overflow  (ovf)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] x);
        n_cmp++;
        if (a !== x) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, a, x, $time);
        end
    endtask

    // Reference model: words queue up, each takes WCYC cycles from its pop
    // edge, and the next pop is allowed on the edge that ends the previous word.
    logic [31:0] mq[$];
    logic [7:0]  expq[$];
    logic [31:0] cur = '0;
    int          e     = 0;
    int          pop_e = 0;
    int          n_clr = 0;
    bit          act   = 0;
    bit          m_ovf = 0;

    always @(posedge clk) begin
        int pre;
        bit pop;
        e++;
        if (clear) begin
            mq.delete();
            expq.delete();
            act   = 0;
            m_ovf = 0;
            n_clr++;
        end else begin
            pre = mq.size();
            pop = 0;
            if (act && e >= pop_e + WCYC) act = 0;
            if (!act && pre > 0) begin
                cur   = mq.pop_front();
                pop_e = e;
                act   = 1;
                pop   = 1;
            end
            if (bus.OutPortin) begin
                if (pre < D || pop) begin
                    mq.push_back(bus.OutPortData);
                    for (int k = 0; k < 4; k++) expq.push_back(bus.OutPortData[8*k +: 8]);
                end else begin
                    m_ovf = 1;
                end
            end
        end
    end

    function automatic logic m_tx();
        int t;
        int s;
        int p;
        logic [7:0] b;
        if (!act) return 1'b1;
        t = e - pop_e;
        s = t / CPB;
        p = s % FB;
        b = cur[8*(s/FB) +: 8];
        if (p == 0) return 1'b0;
        if (p <= 8) return b[p-1];
        if (FB == 11 && p == 9) return ^b;
        return 1'b1;
    endfunction

    bit mon_en = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("tx",       tx,   m_tx());
            chk("busy",     busy, act || mq.size() != 0);
            chk("count",    cnt,  mq.size());
            chk("full",     full, mq.size() == D);
            chk("overflow", ovf,  m_ovf);
        end
    end

    // Line decoder: samples mid-bit, records {framing_ok, byte}.
    logic [8:0] rxq[$];

    initial begin : decoder
        logic [7:0] b;
        bit         ok;
        int         c0;
        forever begin
            @(negedge clk);
            if (!clear && tx === 1'b0) begin
                c0 = n_clr;
                ok = 1;
                b  = '0;
                repeat (CPB/2) @(negedge clk);
                if (tx !== 1'b0) ok = 0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                if (FB == 11) begin
                    repeat (CPB) @(negedge clk);
                    if (tx !== ^b) ok = 0;
                end
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1) ok = 0;
                if (n_clr == c0) rxq.push_back({ok, b});
            end
        end
    end

    task automatic write(input logic [31:0] w);
        bus.OutPortin   = 1'b1;
        bus.OutPortData = w;
        @(negedge clk);
        bus.OutPortin   = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int lim);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: busy still high after %0d cycles, required 0", nm, lim);
        end
    endtask

    task automatic wait_edge(input string nm, input int target, input int lim);
        int k;
        k = 0;
        while (e != target && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_reach"}, e, target);
    endtask

    task automatic check_rx(input string nm);
        chk({nm, "_len"}, rxq.size(), expq.size());
        for (int i = 0; i < rxq.size() && i < expq.size(); i++)
            chk({nm, "_byte"}, rxq[i], {1'b1, expq[i]});
        rxq.delete();
        expq.delete();
    endtask

    typedef struct {
        logic [31:0] w;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int k;
        tbl[0] = '{32'h4433_2211, 8'h11, 8'h22, 8'h33, 8'h44};
        tbl[1] = '{32'h0000_00A5, 8'hA5, 8'h00, 8'h00, 8'h00};
        tbl[2] = '{32'hFFFF_FF5A, 8'h5A, 8'hFF, 8'hFF, 8'hFF};
        tbl[3] = '{32'h80FF_0107, 8'h07, 8'h01, 8'hFF, 8'h80};
        tbl[4] = '{32'hDEAD_BEEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

        bus.OutPortin   = 1'b0;
        bus.OutPortData = '0;
        clear = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1;
        clear  = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_tx",    tx,   1'b1);
        chk("idle_busy",  busy, 1'b0);
        chk("idle_count", cnt,  '0);
        chk("idle_ovf",   ovf,  1'b0);

        for (int i = 0; i < 5; i++) begin
            write(tbl[i].w);
            k = 0;
            while (busy === 1'b1 && k < WCYC + 20) begin
                k++;
                @(negedge clk);
            end
            chk("vec_busy_cycles", k, WCYC + 1);
            chk("vec_nbytes", rxq.size(), 4);
            if (rxq.size() >= 4) begin
                chk("vec_b0", rxq[0], {1'b1, tbl[i].b0});
                chk("vec_b1", rxq[1], {1'b1, tbl[i].b1});
                chk("vec_b2", rxq[2], {1'b1, tbl[i].b2});
                chk("vec_b3", rxq[3], {1'b1, tbl[i].b3});
            end
            rxq.delete();
            expq.delete();
            repeat (5) @(negedge clk);
        end

        write(32'h0000_00A5);
        write(32'hFFFF_FF5A);
        wait_idle("b2b_idle", 3 * WCYC);
        chk("b2b_nbytes", rxq.size(), 8);
        check_rx("b2b");

        for (int i = 0; i < 10; i++) begin
            if (i == 9) chk("ovf_full_at_10th", full, 1'b1);
            write(32'h0101_0101 * (i + 1));
        end
        chk("ovf_set", ovf, 1'b1);
        wait_idle("ovf_idle", 11 * WCYC);
        chk("ovf_sticky", ovf, 1'b1);
        chk("ovf_nbytes", rxq.size(), 36);
        check_rx("ovf");
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("ovf_cleared", ovf, 1'b0);

        write(32'hA0A1_A2A3);
        for (int i = 0; i < 8; i++) write($urandom);
        chk("fp_full", full, 1'b1);
        wait_edge("fp", pop_e + WCYC - 1, WCYC + 10);
        write(32'h5555_AAAA);
        chk("fp_count", cnt, 4'd8);
        chk("fp_ovf",   ovf, 1'b0);
        wait_idle("fp_idle", 12 * WCYC);
        chk("fp_nbytes", rxq.size(), 40);
        check_rx("fp");

        write(32'h1234_5678);
        write(32'h9ABC_DEF0);
        wait_edge("rst", pop_e + (FB + 4) * CPB + 1, WCYC);
        chk("rst_data_bit", tx, 1'b0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("rst_tx",    tx,   1'b1);
        chk("rst_count", cnt,  '0);
        chk("rst_busy",  busy, 1'b0);
        repeat (2 * WCYC) @(negedge clk);
        chk("rst_nbytes", rxq.size(), 1);
        if (rxq.size() >= 1) chk("rst_byte0", rxq[0], {1'b1, 8'h78});
        rxq.delete();
        expq.delete();

        for (int i = 0; i < 600; i++) begin
            bus.OutPortin   = ($urandom_range(0, 15) == 0);
            bus.OutPortData = $urandom;
            @(negedge clk);
        end
        bus.OutPortin = 1'b0;
        wait_idle("rand_idle", 10 * WCYC);
        check_rx("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
